ignition_ctrl: RTL

IGNITION_CTRL -- requirements
Module: ignition_ctrl

---
 rtl/ignition_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ignition_ctrl.sv
// Engine ignition sequencer: prime, crank, run, cool-down with retry counting.
// Optional lockout after MAX_TRIES failed attempts is enabled by defining IGN_LOCKOUT_EN.
module ignition_ctrl #(
  parameter int PRIME_CYC = 2,
  parameter int CRANK_MAX = 8,
  parameter int COOL_CYC  = 16,
  parameter int MAX_TRIES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic rpm_ok,
  output logic fuel_on,
  output logic crank,
  output logic running,
  output logic fault
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PRIME = 3'd1,
    CRANK = 3'd2,
    RUN   = 3'd3,
    COOL  = 3'd4,
    LOCK  = 3'd5
  } state_t;

  localparam logic [7:0] PRIME_END = 8'(PRIME_CYC - 1);
  localparam logic [7:0] CRANK_END = 8'(CRANK_MAX - 1);
  localparam logic [7:0] COOL_END  = 8'(COOL_CYC - 1);
  localparam logic [2:0] TRY_LIM   = 3'(MAX_TRIES);

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  tries;
  logic [2:0]  tries_inc;
  logic [2:0]  outs;   // {fuel_on, crank, running}, loaded with the decode of the next state

  // Moore decode of the non-fault outputs for a given state
  function automatic logic [2:0] dec(input state_t s);
    case (s)
      PRIME:   dec = 3'b100;
      CRANK:   dec = 3'b110;
      RUN:     dec = 3'b101;
      default: dec = 3'b000;
    endcase
  endfunction

  assign tries_inc = (tries == 3'd7) ? 3'd7 : tries + 3'd1;

`ifdef IGN_LOCKOUT_EN
  logic fault_r;
  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  assign fuel_on = outs[2];
  assign crank   = outs[1];
  assign running = outs[0];

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= 8'd0;
      tries <= 3'd0;
      outs  <= 3'b000;
`ifdef IGN_LOCKOUT_EN
      fault_r <= 1'b0;
`endif
    end else begin
      case (state)
        OFF: begin
          if (start && !stop) begin
            state <= PRIME;
            cnt   <= 8'd0;
            outs  <= dec(PRIME);
          end else begin
            outs <= dec(OFF);
          end
        end
        PRIME: begin
          if (stop) begin
            state <= OFF;
            cnt   <= 8'd0;
            outs  <= dec(OFF);
          end else if (cnt == PRIME_END) begin
            state <= CRANK;
            cnt   <= 8'd0;
            outs  <= dec(CRANK);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CRANK: begin
          // stop beats success, success beats timeout
          if (stop) begin
            state <= OFF;
            cnt   <= 8'd0;
            outs  <= dec(OFF);
          end else if (rpm_ok) begin
            state <= RUN;
            cnt   <= 8'd0;
            tries <= 3'd0;
            outs  <= dec(RUN);
          end else if (cnt == CRANK_END) begin
            cnt   <= 8'd0;
            tries <= tries_inc;
            outs  <= dec(COOL);
`ifdef IGN_LOCKOUT_EN
            if (tries_inc == TRY_LIM) begin
              state   <= LOCK;
              fault_r <= 1'b1;
            end else begin
              state <= COOL;
            end
`else
            state <= COOL;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RUN: begin
          if (stop || !rpm_ok) begin
            state <= OFF;
            cnt   <= 8'd0;
            outs  <= dec(OFF);
          end else begin
            outs <= dec(RUN);
          end
        end
        COOL: begin
          if (cnt == COOL_END) begin
            state <= OFF;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
          outs <= dec(OFF);
        end
`ifdef IGN_LOCKOUT_EN
        LOCK: begin
          outs <= dec(LOCK);
        end
`endif
        default: begin
          state <= OFF;
          cnt   <= 8'd0;
          outs  <= dec(OFF);
        end
      endcase
    end
  end

endmodule
